seq_checker: RTL and testbench

Streaming checker downstream of the sequence generator. Consumes its 32-bit output and verifies the Padovan recurrence s[n] = s[n-2] + s[n-3], modulo 2^WIDTH. Reports lock status, per-sample error pulses, the predicted value, and saturating match and error counters. It re-acquires lock automatically when the upstream stream restarts.

---
 rtl/seq_checker.sv | 99 +++++++++
 tb/tb_seq_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_checker.sv
// seq_checker: verifies a Padovan stream s[n] = s[n-2] + s[n-3], with lock tracking and saturating stats.
module seq_checker #(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 16,
    parameter int RESYNC_ERRS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seq_valid_i,
    input  logic [WIDTH-1:0] seq_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [WIDTH-1:0] expected_o,
    output logic [CNT_W-1:0] chk_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);
    localparam int CW = $clog2(RESYNC_ERRS + 1);

    typedef enum logic {FILL, LOCKED} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] h0, h1, h2, h0_d, h1_d, h2_d, pred, exp_d, sh_val;
    logic [1:0]       fill_cnt, fill_d;
    logic [CW-1:0]    consec_err, consec_d, consec_inc;
    logic [CNT_W-1:0] chk_d, errc_d;
    logic             err_d, hit, sh_en;

    assign pred       = h0 + h1;
    assign hit        = seq_i == pred;
    assign consec_inc = consec_err + 1'b1;

    always_comb begin
        state_d  = state;
        fill_d   = fill_cnt;
        consec_d = consec_err;
        exp_d    = expected_o;
        chk_d    = chk_cnt_o;
        errc_d   = err_cnt_o;
        err_d    = 1'b0;
        sh_en    = 1'b0;
        sh_val   = seq_i;
        if (seq_valid_i) begin
            sh_en = 1'b1;
            if (state == FILL) begin
                fill_d  = fill_cnt == 2'd2 ? 2'd0 : fill_cnt + 2'd1;
                state_d = fill_cnt == 2'd2 ? LOCKED : FILL;
            end else begin
                exp_d = pred;
                if (hit) begin
                    chk_d    = &chk_cnt_o ? chk_cnt_o : chk_cnt_o + 1'b1;
                    consec_d = '0;
                end else begin
                    // coast over a glitch by trusting the prediction
                    sh_val = pred;
                    err_d  = 1'b1;
                    errc_d = &err_cnt_o ? err_cnt_o : err_cnt_o + 1'b1;
                    if (consec_inc == CW'(RESYNC_ERRS)) begin
                        state_d  = FILL;
                        fill_d   = 2'd0;
                        consec_d = '0;
                    end else begin
                        consec_d = consec_inc;
                    end
                end
            end
        end
        h0_d = sh_en ? h1 : h0;
        h1_d = sh_en ? h2 : h1;
        h2_d = sh_en ? sh_val : h2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            h0         <= '0;
            h1         <= '0;
            h2         <= '0;
            fill_cnt   <= '0;
            consec_err <= '0;
            locked_o   <= 1'b0;
            err_o      <= 1'b0;
            expected_o <= '0;
            chk_cnt_o  <= '0;
            err_cnt_o  <= '0;
        end else begin
            state      <= state_d;
            h0         <= h0_d;
            h1         <= h1_d;
            h2         <= h2_d;
            fill_cnt   <= fill_d;
            consec_err <= consec_d;
            locked_o   <= state_d == LOCKED;
            err_o      <= err_d;
            expected_o <= exp_d;
            chk_cnt_o  <= chk_d;
            err_cnt_o  <= errc_d;
        end
    end
endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: directed plan scenarios plus random streams against a queue-based reference model.
module tb_seq_checker;
    localparam int CNTW = 4;
    localparam int RES  = 3;
    localparam int SAT  = (1 << CNTW) - 1;

    logic            clk = 0;
    logic            reset = 1;
    logic            seq_valid_i = 0;
    logic [31:0]     seq_i = 0;
    logic            locked_o, err_o;
    logic [31:0]     expected_o;
    logic [CNTW-1:0] chk_cnt_o, err_cnt_o;

    seq_checker #(.WIDTH(32), .CNT_W(CNTW), .RESYNC_ERRS(RES)) dut (
        .clk(clk), .reset(reset), .seq_valid_i(seq_valid_i), .seq_i(seq_i),
        .locked_o(locked_o), .err_o(err_o), .expected_o(expected_o),
        .chk_cnt_o(chk_cnt_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    logic [31:0] q[$];
    bit          m_locked, m_err;
    int          m_fill, m_consec, m_chk, m_errc;
    logic [31:0] m_exp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_pred();
        return q[0] + q[1];
    endfunction

    task automatic model_reset();
        q = '{32'd0, 32'd0, 32'd0};
        m_locked = 0; m_err = 0; m_fill = 0; m_consec = 0;
        m_chk = 0; m_errc = 0; m_exp = 0;
    endtask

    task automatic model_push(input logic [31:0] v);
        q.push_back(v);
        void'(q.pop_front());
    endtask

    task automatic model_step(input bit v, input logic [31:0] d);
        logic [31:0] p;
        m_err = 0;
        if (reset) model_reset();
        else if (v && !m_locked) begin
            model_push(d);
            m_fill++;
            if (m_fill == 3) begin m_locked = 1; m_fill = 0; end
        end else if (v) begin
            p = model_pred();
            m_exp = p;
            if (d == p) begin
                model_push(d);
                m_chk = m_chk == SAT ? SAT : m_chk + 1;
                m_consec = 0;
            end else begin
                model_push(p);
                m_err = 1;
                m_errc = m_errc == SAT ? SAT : m_errc + 1;
                m_consec++;
                if (m_consec == RES) begin m_locked = 0; m_consec = 0; end
            end
        end
    endtask

    task automatic step(input bit v, input logic [31:0] d);
        seq_valid_i = v;
        seq_i = d;
        model_step(v, d);
        @(posedge clk);
        #1;
        if (err_o) pulses++;
        check("locked", locked_o, m_locked);
        check("err", err_o, m_err);
        check("expected", expected_o, m_exp);
        check("chk_cnt", chk_cnt_o, m_chk);
        check("err_cnt", err_cnt_o, m_errc);
    endtask

    task automatic do_reset();
        reset = 1;
        step(0, 0);
        reset = 0;
        pulses = 0;
    endtask

    logic [31:0] clean[12];
    logic [31:0] restart[7];
    logic [31:0] d;

    initial begin
        clean   = '{1, 1, 2, 2, 3, 4, 5, 7, 9, 12, 16, 21};
        restart = '{1, 1, 2, 2, 3, 4, 5};
        model_reset();
        do_reset();
        check("reset_locked", locked_o, 0);
        check("reset_exp", expected_o, 0);

        for (int i = 0; i < 12; i++) begin
            step(1, clean[i]);
            if (i == 1) check("clean_not_locked", locked_o, 0);
            if (i == 2) check("clean_locked", locked_o, 1);
        end
        check("clean_chk", chk_cnt_o, 9);
        check("clean_errc", err_cnt_o, 0);
        check("clean_pulses", pulses, 0);
        check("clean_exp", expected_o, 21);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1, i == 6 ? 32'd6 : clean[i]);
            if (i == 6) begin
                check("glitch_err", err_o, 1);
                check("glitch_exp", expected_o, 5);
            end
        end
        check("glitch_errc", err_cnt_o, 1);
        check("glitch_chk", chk_cnt_o, 8);
        check("glitch_locked", locked_o, 1);
        check("glitch_pulses", pulses, 1);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(0, 32'hDEADBEEF);
            step(1, clean[i]);
        end
        check("gap_chk", chk_cnt_o, 9);
        check("gap_errc", err_cnt_o, 0);
        check("gap_pulses", pulses, 0);

        do_reset();
        for (int i = 0; i < 10; i++) step(1, clean[i]);
        for (int i = 0; i < 7; i++) begin
            step(1, restart[i]);
            if (i == 0) check("rs_exp16", expected_o, 16);
            if (i == 1) check("rs_exp21", expected_o, 21);
            if (i == 2) begin
                check("rs_exp28", expected_o, 28);
                check("rs_drop_err", err_o, 1);
                check("rs_drop_locked", locked_o, 0);
            end
            if (i == 5) check("rs_relock", locked_o, 1);
        end
        check("rs_pulses", pulses, 3);
        check("rs_errc", err_cnt_o, 3);
        check("rs_last_err", err_o, 0);
        check("rs_last_exp", expected_o, 5);

        do_reset();
        step(1, 32'hFFFFFFFF);
        step(1, 32'd2);
        step(1, 32'd7);
        step(1, 32'd1);
        check("wrap_exp", expected_o, 1);
        check("wrap_err", err_o, 0);

        do_reset();
        for (int i = 0; i < 3; i++) step(1, $urandom);
        for (int i = 0; i < 44; i++) begin
            d = model_pred();
            step(1, i % 2 == 0 ? ~d : d);
        end
        check("sat_errc", err_cnt_o, SAT);
        check("sat_chk", chk_cnt_o, SAT);
        check("sat_locked", locked_o, 1);
        step(1, ~model_pred());
        check("sat_err_inflight", err_o, 1);
        reset = 1;
        step(1, ~model_pred());
        reset = 0;
        check("rst_err", err_o, 0);
        check("rst_locked", locked_o, 0);
        check("rst_errc", err_cnt_o, 0);
        check("rst_chk", chk_cnt_o, 0);
        check("rst_exp", expected_o, 0);
        step(1, 32'd4);
        step(1, 32'd9);
        check("relock_2", locked_o, 0);
        step(1, 32'd1);
        check("relock_3", locked_o, 1);

        for (int i = 0; i < 400; i++) begin
            reset = $urandom_range(0, 99) < 2;
            if (m_locked && $urandom_range(0, 3) != 0) d = model_pred();
            else d = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, d);
        end
        reset = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
